// File: rtl/hft_pkg.sv
// Shared encodings for the order manager: decision actions, order sides and FSM states.
package hft_pkg;

    typedef enum logic [1:0] {
        ACT_HOLD = 2'd0,
        ACT_BUY  = 2'd1,
        ACT_SELL = 2'd2
    } action_e;

    localparam logic [1:0] SIDE_NONE = 2'd0;
    localparam logic [1:0] SIDE_BUY  = 2'd1;
    localparam logic [1:0] SIDE_SELL = 2'd2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_SEND     = 3'd1,
        ST_WORK     = 3'd2,
        ST_CANCEL   = 3'd3,
        ST_CXL_WAIT = 3'd4
    } state_e;

endpackage

// File: rtl/hft_timeout_ctr.sv
// Working-order age counter: synchronous clear, count enable, terminal-count flag at TERMINAL-1.
module hft_timeout_ctr #(
    parameter int unsigned TERMINAL = 1000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam int CW = (TERMINAL > 1) ? $clog2(TERMINAL) : 1;

    logic [CW-1:0] count;

    assign tc = (count == CW'(TERMINAL - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (en) begin
            count <= tc ? '0 : count + 1'b1;
        end
    end

endmodule

// File: rtl/hft_order_manager.sv
// Single-order manager: turns strategy decisions into venue orders, tracks fills, cancels on timeout.
// Optional position-limit gate on new orders is enabled by defining HFT_POS_LIMIT_EN.
module hft_order_manager
    import hft_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned TIMEOUT_CYCLES = 1000,
    parameter int unsigned POS_LIMIT      = 200
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic                  dec_valid,
    output logic                  dec_ready,
    input  logic [DATA_WIDTH-1:0] action,
    input  logic [DATA_WIDTH-1:0] price,
    input  logic [DATA_WIDTH-1:0] quantity,
    output logic                  ord_valid,
    input  logic                  ord_ready,
    output logic                  ord_cancel,
    output logic [1:0]            ord_side,
    output logic [DATA_WIDTH-1:0] ord_price,
    output logic [DATA_WIDTH-1:0] ord_qty,
    input  logic                  fill_valid,
    input  logic [DATA_WIDTH-1:0] fill_price,
    input  logic [DATA_WIDTH-1:0] fill_qty,
    input  logic                  cxl_ack,
    output logic [DATA_WIDTH-1:0] current_position,
    output logic [DATA_WIDTH-1:0] last_fill_price,
    output logic [DATA_WIDTH-1:0] last_fill_side,
    output logic                  busy,
    output logic                  overfill_err,
    output logic                  limit_reject
);

    // Decision handshake: a decision is taken on a rising edge where dec_valid && dec_ready.
    // Venue handshake: a request is taken on a rising edge where ord_valid && ord_ready; ord_* are
    // held until then.

    state_e                state;
    logic [DATA_WIDTH-1:0] remaining;
    logic                  timeout_tc;
    logic                  is_trade;
    logic                  take_dec;
    logic                  fill_en;
    logic                  overfill;
    logic [DATA_WIDTH-1:0] applied;
    logic [DATA_WIDTH-1:0] rem_next;
    logic                  limit_over;

    assign dec_ready = ap_rst_n && (state == ST_IDLE);
    assign busy      = (state != ST_IDLE);
    assign is_trade  = (action == DATA_WIDTH'(ACT_BUY)) || (action == DATA_WIDTH'(ACT_SELL));
    assign take_dec  = dec_valid && dec_ready && is_trade && (quantity != '0);
    assign fill_en   = fill_valid &&
                       (state == ST_WORK || state == ST_CANCEL || state == ST_CXL_WAIT);

    always_comb begin
        overfill = fill_qty > remaining;
        applied  = overfill ? remaining : fill_qty;
        rem_next = fill_en ? remaining - applied : remaining;
    end

`ifdef HFT_POS_LIMIT_EN
    localparam logic signed [DATA_WIDTH-1:0] LIM = DATA_WIDTH'(POS_LIMIT);
    logic signed [DATA_WIDTH-1:0] pos_new;

    always_comb begin
        pos_new    = (action[1:0] == SIDE_BUY) ? $signed(current_position + quantity)
                                               : $signed(current_position - quantity);
        limit_over = (pos_new > LIM) || (pos_new < -LIM);
    end
`else
    assign limit_over   = 1'b0;
    assign limit_reject = 1'b0;
`endif

    hft_timeout_ctr #(
        .TERMINAL(TIMEOUT_CYCLES)
    ) u_timeout (
        .clk   (ap_clk),
        .rst_n (ap_rst_n),
        .clr   (state == ST_SEND && ord_ready),
        .en    (state == ST_WORK),
        .tc    (timeout_tc)
    );

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state            <= ST_IDLE;
            remaining        <= '0;
            ord_valid        <= 1'b0;
            ord_cancel       <= 1'b0;
            ord_side         <= SIDE_NONE;
            ord_price        <= '0;
            ord_qty          <= '0;
            current_position <= '0;
            last_fill_price  <= '0;
            last_fill_side   <= '0;
            overfill_err     <= 1'b0;
`ifdef HFT_POS_LIMIT_EN
            limit_reject     <= 1'b0;
`endif
        end else begin
`ifdef HFT_POS_LIMIT_EN
            limit_reject <= 1'b0;
`endif
            if (fill_en) begin
                remaining        <= rem_next;
                current_position <= (ord_side == SIDE_BUY) ? current_position + applied
                                                           : current_position - applied;
                last_fill_price  <= fill_price;
                last_fill_side   <= DATA_WIDTH'(ord_side);
                if (overfill) overfill_err <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (take_dec) begin
                        if (limit_over) begin
`ifdef HFT_POS_LIMIT_EN
                            limit_reject <= 1'b1;
`endif
                        end else begin
                            ord_valid  <= 1'b1;
                            ord_cancel <= 1'b0;
                            ord_side   <= action[1:0];
                            ord_price  <= price;
                            ord_qty    <= quantity;
                            remaining  <= quantity;
                            state      <= ST_SEND;
                        end
                    end
                end
                ST_SEND: begin
                    if (ord_ready) begin
                        ord_valid <= 1'b0;
                        state     <= ST_WORK;
                    end
                end
                ST_WORK: begin
                    // Completion wins over timeout; a same-cycle partial fill shrinks the cancel.
                    if (rem_next == '0) begin
                        state <= ST_IDLE;
                    end else if (timeout_tc) begin
                        ord_valid  <= 1'b1;
                        ord_cancel <= 1'b1;
                        ord_qty    <= rem_next;
                        state      <= ST_CANCEL;
                    end
                end
                ST_CANCEL: begin
                    if (rem_next == '0) begin
                        ord_valid  <= 1'b0;
                        ord_cancel <= 1'b0;
                        state      <= ST_IDLE;
                    end else if (ord_ready) begin
                        ord_valid  <= 1'b0;
                        ord_cancel <= 1'b0;
                        state      <= ST_CXL_WAIT;
                    end else begin
                        ord_qty <= rem_next;
                    end
                end
                ST_CXL_WAIT: begin
                    if (rem_next == '0 || cxl_ack) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hft_order_manager.sv
// Directed bench for hft_order_manager with TIMEOUT_CYCLES=8 and POS_LIMIT=100.
module tb_hft_order_manager;

    localparam int DW = 32;

    logic          ap_clk = 1'b0;
    logic          ap_rst_n = 1'b0;
    logic          dec_valid = 1'b0;
    logic          dec_ready;
    logic [DW-1:0] action = '0;
    logic [DW-1:0] price = '0;
    logic [DW-1:0] quantity = '0;
    logic          ord_valid;
    logic          ord_ready = 1'b0;
    logic          ord_cancel;
    logic [1:0]    ord_side;
    logic [DW-1:0] ord_price;
    logic [DW-1:0] ord_qty;
    logic          fill_valid = 1'b0;
    logic [DW-1:0] fill_price = '0;
    logic [DW-1:0] fill_qty = '0;
    logic          cxl_ack = 1'b0;
    logic [DW-1:0] current_position;
    logic [DW-1:0] last_fill_price;
    logic [DW-1:0] last_fill_side;
    logic          busy;
    logic          overfill_err;
    logic          limit_reject;

    int n_cmp = 0;
    int n_fail = 0;

    hft_order_manager #(
        .DATA_WIDTH(DW),
        .TIMEOUT_CYCLES(8),
        .POS_LIMIT(100)
    ) dut (
        .ap_clk(ap_clk), .ap_rst_n(ap_rst_n),
        .dec_valid(dec_valid), .dec_ready(dec_ready),
        .action(action), .price(price), .quantity(quantity),
        .ord_valid(ord_valid), .ord_ready(ord_ready), .ord_cancel(ord_cancel),
        .ord_side(ord_side), .ord_price(ord_price), .ord_qty(ord_qty),
        .fill_valid(fill_valid), .fill_price(fill_price), .fill_qty(fill_qty),
        .cxl_ack(cxl_ack),
        .current_position(current_position), .last_fill_price(last_fill_price),
        .last_fill_side(last_fill_side), .busy(busy),
        .overfill_err(overfill_err), .limit_reject(limit_reject)
    );

    always #5 ap_clk = ~ap_clk;

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, $signed(obs), $signed(exp));
        end
    endtask

    task automatic do_reset();
        ap_rst_n = 1'b0;
        dec_valid = 1'b0;
        ord_ready = 1'b0;
        fill_valid = 1'b0;
        cxl_ack = 1'b0;
        tick();
        ap_rst_n = 1'b1;
        tick();
    endtask

    task automatic send_dec(input logic [DW-1:0] act, input logic [DW-1:0] p, input logic [DW-1:0] q);
        dec_valid = 1'b1;
        action = act;
        price = p;
        quantity = q;
        tick();
        dec_valid = 1'b0;
    endtask

    task automatic fill(input logic [DW-1:0] p, input logic [DW-1:0] q);
        fill_valid = 1'b1;
        fill_price = p;
        fill_qty = q;
        tick();
        fill_valid = 1'b0;
    endtask

    initial begin
        // Reset values
        #2;
        chk("rst_ord_valid", DW'(ord_valid), 0);
        chk("rst_busy", DW'(busy), 0);
        chk("rst_position", current_position, 0);
        chk("rst_limit_reject", DW'(limit_reject), 0);
        do_reset();
        chk("rel_dec_ready", DW'(dec_ready), 1);

        // Dropped decisions: HOLD, action 3, zero quantity
        send_dec(0, 100, 10);
        chk("hold_busy", DW'(busy), 0);
        send_dec(3, 100, 10);
        chk("act3_busy", DW'(busy), 0);
        send_dec(1, 100, 0);
        chk("qty0_busy", DW'(busy), 0);
        chk("qty0_ord_valid", DW'(ord_valid), 0);

        // S1: BUY 80299 x50, venue ready, single full fill
        ord_ready = 1'b1;
        send_dec(1, 80299, 50);
        chk("s1_ord_valid", DW'(ord_valid), 1);
        chk("s1_ord_cancel", DW'(ord_cancel), 0);
        chk("s1_ord_side", DW'(ord_side), 1);
        chk("s1_ord_price", ord_price, 80299);
        chk("s1_ord_qty", ord_qty, 50);
        chk("s1_dec_ready", DW'(dec_ready), 0);
        tick();
        chk("s1_ord_valid_drop", DW'(ord_valid), 0);
        fill(80299, 50);
        chk("s1_position", current_position, 50);
        chk("s1_last_side", last_fill_side, 1);
        chk("s1_last_price", last_fill_price, 80299);
        chk("s1_busy", DW'(busy), 0);

        // S2: SELL 80300 x50, fills 20 then 30
        do_reset();
        ord_ready = 1'b1;
        send_dec(2, 80300, 50);
        chk("s2_ord_side", DW'(ord_side), 2);
        tick();
        fill(80300, 20);
        chk("s2_pos_partial", current_position, -20);
        chk("s2_busy_partial", DW'(busy), 1);
        fill(80300, 30);
        chk("s2_position", current_position, -50);
        chk("s2_last_side", last_fill_side, 2);
        chk("s2_busy", DW'(busy), 0);

        // S3: no fill, timeout after 8 WORK cycles, cancel x50, cxl_ack
        do_reset();
        ord_ready = 1'b1;
        send_dec(1, 100, 50);
        tick();
        ord_ready = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        chk("s3_no_cancel_yet", DW'(ord_valid), 0);
        tick();
        chk("s3_cxl_valid", DW'(ord_valid), 1);
        chk("s3_cxl_flag", DW'(ord_cancel), 1);
        chk("s3_cxl_qty", ord_qty, 50);
        chk("s3_cxl_side", DW'(ord_side), 1);
        tick();
        chk("s3_cxl_hold", DW'(ord_valid), 1);
        ord_ready = 1'b1;
        tick();
        ord_ready = 1'b0;
        chk("s3_cxlwait_valid", DW'(ord_valid), 0);
        chk("s3_cxlwait_busy", DW'(busy), 1);
        cxl_ack = 1'b1;
        tick();
        cxl_ack = 1'b0;
        chk("s3_busy", DW'(busy), 0);
        chk("s3_position", current_position, 0);

        // S4: full fill lands on the timeout cycle
        do_reset();
        ord_ready = 1'b1;
        send_dec(1, 100, 50);
        tick();
        ord_ready = 1'b0;
        for (int i = 0; i < 7; i++) tick();
        fill(100, 50);
        chk("s4_ord_valid", DW'(ord_valid), 0);
        chk("s4_busy", DW'(busy), 0);
        chk("s4_position", current_position, 50);

        // S5: partial 10, timeout cancel x40, fill 40 with cxl_ack
        do_reset();
        ord_ready = 1'b1;
        send_dec(1, 100, 50);
        tick();
        ord_ready = 1'b0;
        fill(100, 10);
        chk("s5_pos_partial", current_position, 10);
        for (int i = 0; i < 6; i++) tick();
        chk("s5_no_cancel_yet", DW'(ord_valid), 0);
        tick();
        chk("s5_cxl_flag", DW'(ord_cancel), 1);
        chk("s5_cxl_qty", ord_qty, 40);
        ord_ready = 1'b1;
        tick();
        ord_ready = 1'b0;
        cxl_ack = 1'b1;
        fill(101, 40);
        cxl_ack = 1'b0;
        chk("s5_position", current_position, 50);
        chk("s5_last_price", last_fill_price, 101);
        chk("s5_busy", DW'(busy), 0);
        chk("s5_overfill", DW'(overfill_err), 0);

        // S7: overfill 60 on 50
        do_reset();
        ord_ready = 1'b1;
        send_dec(1, 100, 50);
        tick();
        fill(100, 60);
        chk("s7_position", current_position, 50);
        chk("s7_overfill", DW'(overfill_err), 1);
        chk("s7_busy", DW'(busy), 0);
        tick();
        chk("s7_overfill_sticky", DW'(overfill_err), 1);

        // S6: position 80 then BUY 50 against limit 100
        do_reset();
        ord_ready = 1'b1;
        send_dec(1, 100, 80);
        tick();
        fill(100, 80);
        chk("s6_pos80", current_position, 80);
        send_dec(1, 100, 50);
`ifdef HFT_POS_LIMIT_EN
        chk("s6_limit_reject", DW'(limit_reject), 1);
        chk("s6_no_order", DW'(ord_valid), 0);
        chk("s6_busy", DW'(busy), 0);
        tick();
        chk("s6_reject_pulse", DW'(limit_reject), 0);
`else
        chk("s6_limit_reject", DW'(limit_reject), 0);
        chk("s6_order_sent", DW'(ord_valid), 1);
`endif

        // S8: reset while WORK with a non-zero position
        do_reset();
        ord_ready = 1'b1;
        send_dec(1, 200, 50);
        tick();
        ord_ready = 1'b0;
        fill(200, 10);
        chk("s8_pre_position", current_position, 10);
        chk("s8_pre_busy", DW'(busy), 1);
        ap_rst_n = 1'b0;
        #1;
        chk("s8_busy", DW'(busy), 0);
        chk("s8_position", current_position, 0);
        chk("s8_last_price", last_fill_price, 0);
        chk("s8_last_side", last_fill_side, 0);
        chk("s8_ord_valid", DW'(ord_valid), 0);
        chk("s8_ord_qty", ord_qty, 0);
        chk("s8_ord_price", ord_price, 0);
        chk("s8_ord_side", DW'(ord_side), 0);
        tick();
        ap_rst_n = 1'b1;
        tick();
        tick();
        chk("s8_no_cancel", DW'(ord_valid), 0);
        chk("s8_dec_ready", DW'(dec_ready), 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/hft_order_manager.md
HFT_ORDER_MANAGER -- requirements
Module: hft_order_manager

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, width of price, quantity and position buses.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 1000, number of WORK cycles allowed before a cancel is sent.
REQ-003 SHALL have parameter POS_LIMIT, default 200, maximum absolute position; used only under HFT_POS_LIMIT_EN.
REQ-004 SHALL have ports (clock and reset first):
- ap_clk  in  1  clock; one clock; all logic rising-edge.
- ap_rst_n  in  1  reset; asynchronous, active-low.
- dec_valid  in  1  strategy decision valid.
- dec_ready  out  1  decision accepted when high with dec_valid.
- action  in  DATA_WIDTH  0=HOLD, 1=BUY, 2=SELL.
- price  in  DATA_WIDTH  limit price in ticks.
- quantity  in  DATA_WIDTH  order size.
- ord_valid  out  1  order or cancel request to venue.
- ord_ready  in  1  venue accepts request.
- ord_cancel  out  1  request is a cancel.
- ord_side  out  2  1=BUY, 2=SELL.
- ord_price  out  DATA_WIDTH  order price.
- ord_qty  out  DATA_WIDTH  order quantity.
- fill_valid  in  1  partial or full fill report.
- fill_price  in  DATA_WIDTH  fill price.
- fill_qty  in  DATA_WIDTH  filled quantity.
- cxl_ack  in  1  venue confirms cancel; remainder dead.
- current_position  out  DATA_WIDTH  signed net position.
- last_fill_price  out  DATA_WIDTH  price of most recent fill.
- last_fill_side  out  DATA_WIDTH  side of most recent fill (1/2), 0 if none.
- busy  out  1  order outstanding (state != IDLE).
- overfill_err  out  1  sticky; a fill exceeded the remaining quantity.
- limit_reject  out  1  one-cycle pulse; decision dropped by the position limit.

Function
REQ-005 SHALL implement the states IDLE, SEND, WORK, CANCEL and CXL_WAIT.
REQ-006 dec_ready SHALL be 1 only in IDLE.
REQ-007 On a handshake with action 0 or action greater than 2, the decision SHALL be dropped and the state SHALL remain IDLE.
REQ-008 On a handshake with BUY or SELL and quantity 0, the decision SHALL be dropped.
REQ-009 On a handshake with BUY or SELL and quantity not 0: SHALL latch side, price and quantity, set remaining=quantity, and go IDLE->SEND.
REQ-010 In SEND: ord_valid=1 and ord_cancel=0; ord_* SHALL hold stable until ord_ready; on ord_ready -> WORK and the timeout counter clears.
REQ-011 In WORK: the counter SHALL increment every cycle; on reaching TIMEOUT_CYCLES-1 with no fill that cycle -> CANCEL.
REQ-012 In CANCEL: ord_valid=1 and ord_cancel=1 with the same side, price and remaining quantity; on ord_ready -> CXL_WAIT.
REQ-013 A fill_valid SHALL be processed in WORK, CANCEL and CXL_WAIT, and ignored in IDLE and SEND.
REQ-014 Processing a fill SHALL do: applied=min(fill_qty, remaining); remaining-=applied; position +=applied for BUY, -=applied for SELL; last_fill_price=fill_price; last_fill_side=side; if fill_qty>remaining then overfill_err is set.
REQ-015 When remaining reaches 0 in any state, the state SHALL go to IDLE next cycle; this SHALL take priority over timeout and over cxl_ack in the same cycle.
REQ-016 A fill in the same cycle as the timeout SHALL be applied; if remaining is still non-zero, the state goes to CANCEL.
REQ-017 cxl_ack in CXL_WAIT SHALL go to IDLE; a fill in the same cycle SHALL be applied first.
REQ-018 Position arithmetic SHALL be two's-complement DATA_WIDTH wrap with no saturation.
REQ-019 The decision-to-ord_valid latency SHALL be 1 cycle, registered.

Reset
REQ-020 ap_rst_n low SHALL immediately set:
- state=IDLE.
- all outputs 0: ord_valid, ord_cancel, ord_side, ord_price, ord_qty, busy, position, last_fill_*, overfill_err, limit_reject.
- dec_ready=1 once reset is released.
REQ-021 Reset mid-order SHALL abandon the order silently; no cancel is issued.

Configuration
REQ-022 With HFT_POS_LIMIT_EN defined: a BUY whose |position+quantity|>POS_LIMIT, or a SELL whose |position-quantity|>POS_LIMIT, SHALL be dropped in IDLE and limit_reject SHALL pulse for 1 cycle.
REQ-023 Without HFT_POS_LIMIT_EN: no check is made and limit_reject SHALL be tied 0.

Structure
REQ-024 Package hft_pkg SHALL hold the action/side encodings (HOLD/BUY/SELL) and the state enum.
REQ-025 Sub-module hft_timeout_ctr SHALL provide the clear/enable counter with a terminal-count flag.

Verification
REQ-026 The bench SHALL cover these directed scenarios:
- BUY 80299 qty 50, ord_ready held 1, fill 50@80299 -> ord_valid 1 cycle after decision; position=50; last_fill_side=1; IDLE.
- SELL 80300 qty 50 with fills 20 then 30 -> position=-50 after the second fill; busy falls the cycle after.
- BUY qty 50, no fill, TIMEOUT_CYCLES=8 -> cancel with ord_qty=50; cxl_ack -> IDLE; position unchanged.
- Timeout cycle coincides with fill 50 -> no cancel; IDLE; position=50.
- Partial fill 10, then cancel, then fill 40 in the cxl_ack cycle -> position=50; IDLE.
- HFT_POS_LIMIT_EN with POS_LIMIT=100 and position 80, BUY 50 -> limit_reject pulse; no ord_valid.
- Overfill: fill 60 on qty 50 -> position=50; overfill_err=1.
- Reset during WORK -> all outputs 0 immediately.
